// File: rtl/dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter_if
// Description : Bundle of requester-side and DMA-side signals of the DMA
//               arbiter. The arbiter uses the slave modport; the requester /
//               DMA environment uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
);
  // Requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_mode;
  logic [NUM_REQ-1:0]            req_src_sel;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_done;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;

  // DMA side
  logic                          dma_start;
  logic                          dma_mode;
  logic                          dma_src_sel;
  logic [ADDR_WIDTH-1:0]         dma_addr;
  logic [DATA_WIDTH-1:0]         dma_data_in;
  logic                          dma_done;
  logic [DATA_WIDTH-1:0]         dma_data_out;

  modport slave (
    input  req, req_mode, req_src_sel, req_addr, req_data_in,
    input  dma_done, dma_data_out,
    output gnt, rsp_done, rsp_err, rsp_data, busy,
    output dma_start, dma_mode, dma_src_sel, dma_addr, dma_data_in
  );

  modport master (
    output req, req_mode, req_src_sel, req_addr, req_data_in,
    output dma_done, dma_data_out,
    input  gnt, rsp_done, rsp_err, rsp_data, busy,
    input  dma_start, dma_mode, dma_src_sel, dma_addr, dma_data_in
  );
endinterface
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter
// Description : Round-robin arbiter sharing one DMA engine among NUM_REQ
//               requesters. Latches the winner's command, pulses dma_start,
//               waits for dma_done (with optional watchdog abort) and returns
//               the result with a per-requester one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_arbiter_if.slave  bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  // Counter only needs to hold TIMEOUT_CYCLES-1; the limit test fires on it.
  localparam int WDW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LIMIT =
    WDW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic [IDXW-1:0]       last_q;
  logic [WDW-1:0]        wdog_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    rsp_done_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  busy_q;
  logic                  dma_start_q;
  logic                  dma_mode_q;
  logic                  dma_src_sel_q;
  logic [ADDR_WIDTH-1:0] dma_addr_q;
  logic [DATA_WIDTH-1:0] dma_data_in_q;

  // Round-robin winner for the current request vector
  logic                  pick_valid_d;
  logic [IDXW-1:0]       pick_idx_d;

  // Per-requester views of the packed command buses
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[gi] = bus.req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan last+1, last+2, ... (mod NUM_REQ); scanning backwards lets the
  // nearest candidate overwrite farther ones.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[IDXW'((int'(last_q) + k) % NUM_REQ)]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = IDXW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // Arbitration / transaction FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_q        <= IDXW'(NUM_REQ - 1);
      wdog_q        <= '0;
      gnt_q         <= '0;
      rsp_done_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
      dma_start_q   <= 1'b0;
      dma_mode_q    <= 1'b0;
      dma_src_sel_q <= 1'b0;
      dma_addr_q    <= '0;
      dma_data_in_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid_d) begin
            gnt_q         <= GNT_ONE << pick_idx_d;
            dma_mode_q    <= bus.req_mode[pick_idx_d];
            dma_src_sel_q <= bus.req_src_sel[pick_idx_d];
            dma_addr_q    <= addr_arr[pick_idx_d];
            dma_data_in_q <= data_arr[pick_idx_d];
            last_q        <= pick_idx_d;
            dma_start_q   <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dma_start_q <= 1'b0;
          wdog_q      <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // dma_done takes precedence over a simultaneous watchdog expiry
          if (bus.dma_done) begin
            rsp_data_q <= bus.dma_data_out;
            rsp_err_q  <= 1'b0;
            rsp_done_q <= gnt_q;
            state_q    <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (wdog_q == WD_LIMIT) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
              rsp_done_q <= gnt_q;
              state_q    <= S_RESP;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          gnt_q      <= '0;
          rsp_done_q <= '0;
          rsp_err_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_done    = rsp_done_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = busy_q;
  assign bus.dma_start   = dma_start_q;
  assign bus.dma_mode    = dma_mode_q;
  assign bus.dma_src_sel = dma_src_sel_q;
  assign bus.dma_addr    = dma_addr_q;
  assign bus.dma_data_in = dma_data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_arbiter
// Description : Self-checking bench for dma_arbiter. A transaction-level
//               model (round-robin pick, latched command, DMA latency,
//               watchdog limit) predicts every observed output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int AW = 4;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dma_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dma_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: index of the most recently granted requester
  int            model_last = NR - 1;
  logic [DW-1:0] model_rsp  = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(model_last + k) % NR]) return (model_last + k) % NR;
    end
    return -1;
  endfunction

  task automatic scramble_cmds();
    for (int i = 0; i < NR; i++) begin
      bus.req_mode[i]              = 1'($urandom_range(0, 1));
      bus.req_src_sel[i]           = 1'($urandom_range(0, 1));
      bus.req_addr[i*AW +: AW]     = AW'($urandom_range(0, 15));
      bus.req_data_in[i*DW +: DW]  = rand128();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},       DW'(bus.gnt),         '0);
    chk({tag, "_rsp_done"},  DW'(bus.rsp_done),    '0);
    chk({tag, "_rsp_err"},   DW'(bus.rsp_err),     '0);
    chk({tag, "_rsp_data"},  bus.rsp_data,         '0);
    chk({tag, "_busy"},      DW'(bus.busy),        '0);
    chk({tag, "_dma_start"}, DW'(bus.dma_start),   '0);
    chk({tag, "_dma_mode"},  DW'(bus.dma_mode),    '0);
    chk({tag, "_dma_src"},   DW'(bus.dma_src_sel), '0);
    chk({tag, "_dma_addr"},  DW'(bus.dma_addr),    '0);
    chk({tag, "_dma_din"},   bus.dma_data_in,      '0);
  endtask

  // One full transaction starting from IDLE with bus.req already driven.
  // wait_cycles = number of WAIT cycles without dma_done before it is
  // asserted (negative = never). Ends observing the IDLE cycle after RESP.
  task automatic run_txn(input string tag, input int wait_cycles,
                         input logic [DW-1:0] rdata, input bit drop,
                         input bit scramble);
    int            g;
    int            n;
    bit            fin;
    logic [NR-1:0] oh;
    logic          e_mode, e_src;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    g = rr_pick(bus.req);
    if (g < 0) return;
    oh     = '0;
    oh[g]  = 1'b1;
    e_mode = bus.req_mode[g];
    e_src  = bus.req_src_sel[g];
    e_addr = bus.req_addr[g*AW +: AW];
    e_din  = bus.req_data_in[g*DW +: DW];
    bus.dma_done = 1'b0;
    step();                                   // ISSUE cycle
    model_last = g;
    chk({tag, "_gnt"},       DW'(bus.gnt),         DW'(oh));
    chk({tag, "_start"},     DW'(bus.dma_start),   DW'(1));
    chk({tag, "_busy"},      DW'(bus.busy),        DW'(1));
    chk({tag, "_mode"},      DW'(bus.dma_mode),    DW'(e_mode));
    chk({tag, "_src"},       DW'(bus.dma_src_sel), DW'(e_src));
    chk({tag, "_addr"},      DW'(bus.dma_addr),    DW'(e_addr));
    chk({tag, "_din"},       bus.dma_data_in,      e_din);
    chk({tag, "_done_iss"},  DW'(bus.rsp_done),    '0);
    if (scramble) scramble_cmds();
    bus.dma_done     = 1'($urandom_range(0, 1)); // must be ignored in ISSUE
    bus.dma_data_out = rand128();
    step();                                   // first WAIT cycle
    chk({tag, "_start_off"}, DW'(bus.dma_start),   '0);
    chk({tag, "_addr_hold"}, DW'(bus.dma_addr),    DW'(e_addr));
    chk({tag, "_din_hold"},  bus.dma_data_in,      e_din);
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      bus.dma_done     = (n == wait_cycles);
      bus.dma_data_out = (n == wait_cycles) ? rdata : rand128();
      step();
      if (n == wait_cycles) begin
        chk({tag, "_rsp_done"}, DW'(bus.rsp_done), DW'(oh));
        chk({tag, "_rsp_err"},  DW'(bus.rsp_err),  '0);
        chk({tag, "_rsp_data"}, bus.rsp_data,      rdata);
        chk({tag, "_gnt_resp"}, DW'(bus.gnt),      DW'(oh));
        model_rsp = rdata;
        fin = 1'b1;
      end else if (n + 1 == TO) begin
        chk({tag, "_to_done"},  DW'(bus.rsp_done), DW'(oh));
        chk({tag, "_to_err"},   DW'(bus.rsp_err),  DW'(1));
        chk({tag, "_to_data"},  bus.rsp_data,      '0);
        model_rsp = '0;
        fin = 1'b1;
      end else begin
        chk({tag, "_no_done"},  DW'(bus.rsp_done), '0);
        chk({tag, "_gnt_wait"}, DW'(bus.gnt),      DW'(oh));
      end
      n++;
    end
    if (drop) bus.req[g] = 1'b0;
    bus.dma_done     = 1'($urandom_range(0, 1)); // must be ignored in RESP
    bus.dma_data_out = rand128();
    step();                                   // back in IDLE
    chk({tag, "_gnt_clr"},   DW'(bus.gnt),      '0);
    chk({tag, "_done_clr"},  DW'(bus.rsp_done), '0);
    chk({tag, "_err_clr"},   DW'(bus.rsp_err),  '0);
    chk({tag, "_busy_clr"},  DW'(bus.busy),     '0);
    chk({tag, "_data_hold"}, bus.rsp_data,      model_rsp);
    bus.dma_done = 1'b0;
  endtask

  initial begin
    bus.req          = '0;
    bus.req_mode     = '0;
    bus.req_src_sel  = '0;
    bus.req_addr     = '0;
    bus.req_data_in  = '0;
    bus.dma_done     = 1'b0;
    bus.dma_data_out = '0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // Single store from requester 0
    bus.req                 = 4'b0001;
    bus.req_mode[0]         = 1'b1;
    bus.req_src_sel[0]      = 1'b1;
    bus.req_addr[0 +: AW]   = 4'd3;
    bus.req_data_in[0 +: DW] = 128'h00112233445566778899AABBCCDDEEFF;
    run_txn("t1", 2, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C, 1'b1, 1'b1);

    // Two simultaneous loads from RoundKeyMemory
    bus.req                   = 4'b1010;
    bus.req_mode              = '0;
    bus.req_src_sel           = '0;
    bus.req_addr[1*AW +: AW]  = 4'd5;
    bus.req_addr[3*AW +: AW]  = 4'd7;
    run_txn("t2a", 1, 128'h5555_0000_1111_2222_3333_4444_6666_7777, 1'b1, 1'b0);
    run_txn("t2b", 0, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 1'b1, 1'b0);

    // All four requesting continuously for eight transactions
    bus.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      scramble_cmds();
      run_txn("t3", $urandom_range(0, 3), rand128(), 1'b0, 1'b1);
    end
    bus.req = '0;

    // Stray dma_done in IDLE has no effect
    bus.dma_done     = 1'b1;
    bus.dma_data_out = rand128();
    step();
    bus.dma_done = 1'b0;
    chk("stray_gnt",   DW'(bus.gnt),       '0);
    chk("stray_done",  DW'(bus.rsp_done),  '0);
    chk("stray_busy",  DW'(bus.busy),      '0);
    chk("stray_start", DW'(bus.dma_start), '0);
    chk("stray_data",  bus.rsp_data,       model_rsp);

    // Watchdog abort, then a normal transaction
    bus.req = 4'b0100;
    run_txn("t4_to", -1, '0, 1'b1, 1'b1);
    bus.req = 4'b0001;
    run_txn("t4_next", 1, rand128(), 1'b1, 1'b1);

    // dma_done on the very cycle the watchdog limit is reached
    bus.req = 4'b0010;
    run_txn("t6_tie", TO - 1, 128'hFEEDFACE_DEADBEEF_01234567_89ABCDEF, 1'b1, 1'b1);

    // Reset in the middle of WAIT
    bus.req = 4'b0001;
    step();                                   // ISSUE
    bus.req = '0;
    step();                                   // WAIT
    step();                                   // WAIT
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    bus.dma_done     = 1'b1;
    bus.dma_data_out = rand128();
    step();
    bus.dma_done = 1'b0;
    chk("rst_hold_done", DW'(bus.rsp_done), '0);
    chk("rst_hold_gnt",  DW'(bus.gnt),      '0);
    rst_n      = 1'b1;
    model_last = NR - 1;
    model_rsp  = '0;
    step();
    bus.req = 4'b0100;
    scramble_cmds();
    run_txn("t5", 0, rand128(), 1'b1, 1'b1);

    // Round-robin priority right after reset favours requester 0
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    model_last = NR - 1;
    model_rsp  = '0;
    step();
    bus.req = 4'b1100;
    scramble_cmds();
    run_txn("t5b", 0, rand128(), 1'b1, 1'b1);
    bus.req = '0;

    // Random traffic against the transaction model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) bus.req = bus.req | NR'($urandom_range(0, 15));
      if (bus.req == '0) begin
        step();
        chk("rnd_idle_busy", DW'(bus.busy), '0);
        chk("rnd_idle_gnt",  DW'(bus.gnt),  '0);
        bus.req = NR'($urandom_range(1, 15));
      end
      scramble_cmds();
      run_txn("rnd", $urandom_range(0, 5), rand128(), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Round-robin arbiter that shares the single 128-bit DMA engine (RoundKeyMemory plus state RAM) among NUM_REQ requesters, e.g. several AES cores or key-load and state paths.
- Latches the granted requester's command, issues one DMA start pulse, waits for dma_done, then returns the result with a per-requester done pulse.
- A watchdog releases the DMA if dma_done never arrives.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 128: DMA data width.
- ADDR_WIDTH, 4: DMA address width.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort. 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_mode  in  NUM_REQ  per-requester mode: 0 = load, 1 = store.
- req_src_sel  in  NUM_REQ  per-requester select: 0 = RoundKeyMemory, 1 = state RAM.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data_in  in  NUM_REQ*DATA_WIDTH  packed store data, sliced the same way.
- gnt  out  NUM_REQ  one-hot grant, registered.
- rsp_done  out  NUM_REQ  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_done. 1 = timeout abort.
- rsp_data  out  DATA_WIDTH  load result, valid with rsp_done.
- busy  out  1  high whenever state is not IDLE.
- dma_start  out  1  one-cycle start pulse to the DMA.
- dma_mode, dma_src_sel  out  1 each  latched command fields.
- dma_addr  out  ADDR_WIDTH  latched address.
- dma_data_in  out  DATA_WIDTH  latched store data.
- dma_done  in  1  DMA completion.
- dma_data_out  in  DATA_WIDTH  DMA load data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: gnt, rsp_done, rsp_err, rsp_data, busy, dma_start, dma_mode, dma_src_sel, dma_addr, dma_data_in.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
  - Watchdog counter 0.
  - Reset mid-transaction abandons it silently: no rsp_done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any req bit is set, pick the first set index scanning last+1, last+2, ... modulo NUM_REQ.
  - Set gnt to that one-hot value.
  - Latch mode, src_sel, addr and data_in onto the dma_* outputs.
  - Set last to the granted index and dma_start=1, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - dma_start is high for exactly this one cycle.
  - Clear dma_start, clear the watchdog, go to WAIT.
  - dma_done is ignored in ISSUE.
- WAIT:
  - dma_* outputs and gnt stay stable.
  - On dma_done=1:
    - rsp_data = dma_data_out; this applies for store too, and the DMA defines the value.
    - rsp_err=0.
    - rsp_done[granted]=1.
    - Go to RESP.
  - Otherwise increment the watchdog. When TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES:
    - rsp_err=1, rsp_data=0, rsp_done[granted]=1.
    - Go to RESP.
  - If dma_done and the timeout coincide, dma_done wins.
- RESP:
  - rsp_done and rsp_err are high for this single cycle.
  - Next cycle: clear gnt, rsp_done and rsp_err; go to IDLE.
  - rsp_data holds until the next response.
- Timing from a request seen at cycle T:
  - gnt and dma_start visible at T+1.
  - dma_done at earliest T+2; rsp_done at T+3.
  - gnt cleared at T+4.
  - Throughput is at most one transaction per 4 cycles.
- Requester protocol:
  - Hold req until rsp_done.
  - Command fields only need to be valid in the cycle gnt is set, because they are latched.
  - Dropping req after grant does not cancel the transaction; rsp_done still pulses.
  - If req is still high in the cycle after rsp_done, it counts as a new request and competes under round-robin.
- Stray dma_done in IDLE, ISSUE or RESP is ignored with no output change.
- gnt is never more than one-hot. Only one DMA transaction is outstanding at a time.

Test Plan:
- req=0001, store, src_sel=1, addr=3, data=0x00112233445566778899AABBCCDDEEFF; DMA done after 2 WAIT cycles -> one dma_start pulse with those fields, rsp_done=0001, rsp_err=0, gnt=0001 for 4 cycles total.
- req=1010 simultaneously after reset, loads from RoundKeyMemory addr 5 and 7 -> grant order 0010 then 1000; rsp_data equals the model DMA data for each; no overlap.
- req=1111 held continuously for 8 transactions -> grant sequence 0001, 0010, 0100, 1000, 0001, ... with each requester served exactly twice.
- TIMEOUT_CYCLES=64, DMA never asserts done -> rsp_done pulses 64 WAIT cycles after ISSUE with rsp_err=1 and rsp_data=0; the next request is served normally.
- Pull rst_n low during WAIT -> all outputs 0 immediately, no rsp_done; after release, req=0100 -> granted 0100 first.
- Pulse dma_done in IDLE, then dma_done coinciding with the watchdog limit -> first has no effect; second gives rsp_err=0 with valid data.
